// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_REDIR = 1'b1;

  // Encodings kept identical to the legacy ST_* values.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  output logic              load_use
);

  // x0 is never a real dependency, so a load to x0 cannot stall ID.
  always_comb begin
    load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: pipeline-register enables/flushes, PC write, IFU handshake,
// load-use stall, LSU freeze, EX redirect with in-flight fetch drop, ebreak halt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  input  logic              ifu_rsp_valid,
  output logic              ifu_rsp_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_ebreak,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_redirect_pc,
  input  logic              lsu_busy,
  output logic              pc_wen,
  output logic              pc_sel,
  output logic [31:0]       redirect_pc,
  output logic              if_id_wen,
  output logic              if_id_flush,
  output logic              id_ex_wen,
  output logic              id_ex_flush,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt
);

  state_e            state_q, state_d;
  logic              outstanding_q, outstanding_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              load_use;
  logic              req_fire, rsp_fire, stall_evt;

  hazard_unit #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_rd     (ex_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .load_use  (load_use)
  );

  // Control outputs and next state; flush with wen=1 loads a NOP/bubble.
  always_comb begin
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    pc_wen        = 1'b0;
    pc_sel        = PC_SEL_SEQ;
    redirect_pc   = ex_redirect_pc;
    if_id_wen     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_wen     = 1'b0;
    id_ex_flush   = 1'b0;
    halted        = 1'b0;
    state_d       = state_q;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          ifu_req_valid = !outstanding_q;
          if (lsu_busy) begin
            // Freeze: nothing advances, redirect waits for the LSU.
          end else if (ex_redirect) begin
            pc_wen        = 1'b1;
            pc_sel        = PC_SEL_REDIR;
            if_id_wen     = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_wen     = 1'b1;
            id_ex_flush   = 1'b1;
            ifu_rsp_ready = 1'b1;
            if (outstanding_q && !ifu_rsp_valid) begin
              state_d = ST_DRAIN;
            end
          end else if (load_use) begin
            id_ex_wen   = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            id_ex_wen = 1'b1;
            if_id_wen = 1'b1;
            if (ifu_rsp_valid) begin
              ifu_rsp_ready = 1'b1;
              pc_wen        = 1'b1;
            end else begin
              if_id_flush = 1'b1;
            end
          end
          if (id_ebreak && id_ex_wen && !id_ex_flush) begin
            state_d = ST_HALT;
          end
        end
        ST_DRAIN: begin
          ifu_rsp_ready = 1'b1;
          if_id_wen     = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_wen     = 1'b1;
          id_ex_flush   = 1'b1;
          if (ifu_rsp_valid) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Fetch tracking and stall counter; a stall is any running cycle that
  // captures no real instruction into IF/ID (frozen or NOP-loaded).
  always_comb begin
    req_fire      = ifu_req_valid && ifu_req_ready;
    rsp_fire      = ifu_rsp_valid && ifu_rsp_ready;
    outstanding_d = outstanding_q;
    if (rsp_fire) begin
      outstanding_d = 1'b0;
    end else if (req_fire) begin
      outstanding_d = 1'b1;
    end
    stall_evt   = !rst && ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) &&
                  (!if_id_wen || if_id_flush);
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    stall_cnt = stall_cnt_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      outstanding_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed control vectors.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_ready, ifu_rsp_valid;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_ebreak;
  logic        ex_valid, ex_is_load, ex_redirect, lsu_busy;
  logic [31:0] ex_redirect_pc;

  logic        ifu_req_valid, ifu_rsp_ready, pc_wen, pc_sel;
  logic        if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, halted;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cnt;

  logic        s_req_valid, s_rsp_ready, s_pc_wen, s_pc_sel;
  logic        s_if_id_wen, s_if_id_flush, s_id_ex_wen, s_id_ex_flush, s_halted;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // {req_v, rsp_rdy, pc_wen, pc_sel, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, halted}
  logic [8:0] obs;
  assign obs = {ifu_req_valid, ifu_rsp_ready, pc_wen, pc_sel, if_id_wen,
                if_id_flush, id_ex_wen, id_ex_flush, halted};

  localparam logic [8:0] V_RST   = 9'b0_0_0_0_0_1_0_1_0;
  localparam logic [8:0] V_GAP   = 9'b1_0_0_0_1_1_1_0_0;
  localparam logic [8:0] V_TAKE  = 9'b0_1_1_0_1_0_1_0_0;
  localparam logic [8:0] V_TAKEN = 9'b1_1_1_0_1_0_1_0_0;
  localparam logic [8:0] V_LU    = 9'b1_0_0_0_0_0_1_1_0;
  localparam logic [8:0] V_REDO  = 9'b0_1_1_1_1_1_1_1_0;
  localparam logic [8:0] V_REDN  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] V_DRAIN = 9'b0_1_0_0_1_1_1_1_0;
  localparam logic [8:0] V_BUSY  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_HALT  = 9'b0_0_0_0_0_0_0_0_1;

  pipe_ctrl #(.PERF_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ebreak(id_ebreak), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .lsu_busy(lsu_busy),
    .pc_wen(pc_wen), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .if_id_wen(if_id_wen), .if_id_flush(if_id_flush),
    .id_ex_wen(id_ex_wen), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance to exercise saturation.
  pipe_ctrl #(.PERF_W(2), .REG_AW(5)) dut_sat (
    .clk(clk), .rst(rst),
    .ifu_req_valid(s_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(s_rsp_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ebreak(id_ebreak), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .lsu_busy(lsu_busy),
    .pc_wen(s_pc_wen), .pc_sel(s_pc_sel), .redirect_pc(s_redirect_pc),
    .if_id_wen(s_if_id_wen), .if_id_flush(s_if_id_flush),
    .id_ex_wen(s_id_ex_wen), .id_ex_flush(s_id_ex_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are combinational: sample mid-cycle, then advance past the edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_ebreak = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0; lsu_busy = 1'b0;
    ex_redirect_pc = 32'h8000_0100;

    // Reset
    sample();
    chk("rst_vec", 64'(obs), 64'(V_RST));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: response every second cycle; gaps insert NOPs and count as stalls
    for (int i = 0; i < 3; i++) begin
      ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0;
      sample();
      chk("t1_gap_vec", 64'(obs), 64'(V_GAP));
      chk("t1_gap_cnt", 64'(stall_cnt), 64'(i));
      next_cycle();
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1;
      sample();
      chk("t1_rsp_vec", 64'(obs), 64'(V_TAKE));
      chk("t1_rsp_cnt", 64'(stall_cnt), 64'(i + 1));
      next_cycle();
    end

    // 2: lw x5 in EX, add x6,x5,x1 in ID -> one bubble
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    sample();
    chk("t2_lu_vec", 64'(obs), 64'(V_LU));
    chk("t2_lu_cnt", 64'(stall_cnt), 64'd3);
    chk("t2_sat_cnt", 64'(s_stall_cnt), 64'd3);
    next_cycle();
    ex_valid = 1'b0;
    sample();
    chk("t2_adv_vec", 64'(obs), 64'(V_TAKEN));
    chk("t2_adv_cnt", 64'(stall_cnt), 64'd4);
    chk("t2_sat_nowrap", 64'(s_stall_cnt), 64'd3);
    next_cycle();

    // 3: no stall when rd=x0 or the operand is unused; rs2 match does stall
    ex_valid = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    sample();
    chk("t3_rd0_vec", 64'(obs), 64'(V_TAKEN));
    next_cycle();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    sample();
    chk("t3_nouse_vec", 64'(obs), 64'(V_TAKEN));
    next_cycle();
    id_use_rs2 = 1'b1;
    sample();
    chk("t3_rs2_vec", 64'(obs), 64'(V_LU));
    next_cycle();
    ex_is_load = 1'b0;
    sample();
    chk("t3_noload_vec", 64'(obs), 64'(V_TAKEN));
    chk("t3_cnt", 64'(stall_cnt), 64'd5);
    next_cycle();
    ex_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;

    // 4: redirect with fetch outstanding -> DRAIN, late response dropped
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0;
    sample();
    chk("t4_req_vec", 64'(obs), 64'(V_GAP));
    next_cycle();
    ifu_req_ready = 1'b0; ex_redirect = 1'b1;
    sample();
    chk("t4_redir_vec", 64'(obs), 64'(V_REDO));
    chk("t4_redir_pc", 64'(redirect_pc), 64'h8000_0100);
    next_cycle();
    ex_redirect = 1'b0;
    sample();
    chk("t4_drain1_vec", 64'(obs), 64'(V_DRAIN));
    next_cycle();
    ifu_rsp_valid = 1'b1;
    sample();
    chk("t4_drain2_vec", 64'(obs), 64'(V_DRAIN));
    next_cycle();
    ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b1;
    sample();
    chk("t4_refetch_vec", 64'(obs), 64'(V_GAP));
    chk("t4_cnt", 64'(stall_cnt), 64'd9);
    next_cycle();
    // redirect coinciding with the response: no DRAIN
    ifu_req_ready = 1'b0; ex_redirect = 1'b1; ifu_rsp_valid = 1'b1;
    sample();
    chk("t4_same_vec", 64'(obs), 64'(V_REDO));
    next_cycle();
    ex_redirect = 1'b0; ifu_rsp_valid = 1'b0;
    sample();
    chk("t4_nodrain_vec", 64'(obs), 64'(V_GAP));
    chk("t4_cnt2", 64'(stall_cnt), 64'd11);
    next_cycle();

    // 5: lsu_busy for 4 cycles holds back a pending redirect
    lsu_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t5_busy_vec", 64'(obs), 64'(V_BUSY));
      next_cycle();
    end
    lsu_busy = 1'b0;
    sample();
    chk("t5_redir_vec", 64'(obs), 64'(V_REDN));
    chk("t5_cnt", 64'(stall_cnt), 64'd16);
    next_cycle();
    ex_redirect = 1'b0;

    // 6: ebreak enters EX -> HALT until reset
    id_ebreak = 1'b1; ifu_rsp_valid = 1'b1;
    sample();
    chk("t6_ebreak_vec", 64'(obs), 64'(V_TAKEN));
    next_cycle();
    id_ebreak = 1'b0; ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t6_halt_vec", 64'(obs), 64'(V_HALT));
      chk("t6_halt_cnt", 64'(stall_cnt), 64'd17);
      next_cycle();
    end
    rst = 1'b1; ifu_req_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    sample();
    chk("t6_post_rst_vec", 64'(obs), 64'(V_GAP));
    chk("t6_post_rst_cnt", 64'(stall_cnt), 64'd0);
    chk("t6_post_rst_sat", 64'(s_stall_cnt), 64'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
